mem_array_pipe: RTL and testbench

//  Registered, back-pressurable pipeline carrying a scalar word, a 1-D array and a 2-D unpacked

---
 rtl/mem_array_pkg.sv | 14 +
 rtl/mem_array_skid.sv | 51 +++++
 rtl/mem_array_pipe.sv | 106 ++++++++++
 tb/tb_mem_array_pipe.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_array_pkg.sv
// Shared constants for the array-payload pipeline: default geometry and the
// beat counter width, plus the flat payload size helper used by the top.
package mem_array_pkg;
  localparam int WIDTH_DEF  = 16;
  localparam int ROWS_DEF   = 4;
  localparam int COLS_DEF   = 5;
  localparam int DEPTH_DEF  = 2;
  localparam int BEAT_CNT_W = 16;

  // Bits needed for scalar + 1-D + 2-D elements packed side by side
  function automatic int payload_bits(int width, int rows, int cols);
    return width * (1 + rows + rows * cols);
  endfunction
endpackage

// File: rtl/mem_array_skid.sv
// One 2-entry skid stage over a flat payload. in_ready comes straight from the
// skid flag, so no combinational ready path crosses the stage.
module mem_array_skid #(
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);
  logic          main_valid, skid_valid;
  logic [PW-1:0] main_data, skid_data;
  logic          take_in, load_main;

  // Input is accepted only while the skid slot is free; main advances when empty or drained
  assign take_in   = in_valid && !skid_valid;
  assign load_main = !main_valid || out_ready;

  // Main/skid update: skid drains first, otherwise a new beat lands in main,
  // and only a beat arriving against a stalled, full main is parked in skid
  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (load_main) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
      end else if (take_in) begin
        main_data  <= in_data;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (take_in) begin
      skid_data  <= in_data;
      skid_valid <= 1'b1;
    end
  end

  assign in_ready  = !skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;
endmodule

// File: rtl/mem_array_pipe.sv
// Back-pressurable DEPTH-stage pipeline carrying a scalar, a 1-D and a 2-D
// array payload as one beat, with an output handshake counter.
// Optional feature macro: MEM_ARRAY_PIPE_PARITY_EN adds o_parity, the XOR of
// every input element, carried alongside the beat.
module mem_array_pipe
  import mem_array_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      i3,
  input  logic [WIDTH-1:0]      i34  [ROWS],
  input  logic [WIDTH-1:0]      i345 [ROWS][COLS],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      o3,
  output logic [WIDTH-1:0]      o34  [ROWS],
  output logic [WIDTH-1:0]      o345 [ROWS][COLS],
  output logic [BEAT_CNT_W-1:0] beat_cnt
`ifdef MEM_ARRAY_PIPE_PARITY_EN
  ,
  output logic [WIDTH-1:0]      o_parity
`endif
);
  localparam int DW = payload_bits(WIDTH, ROWS, COLS);
`ifdef MEM_ARRAY_PIPE_PARITY_EN
  localparam int PW = DW + WIDTH;
`else
  localparam int PW = DW;
`endif

  logic [DEPTH:0]         vld_pipe, rdy_pipe;
  logic [DEPTH:0][PW-1:0] dat_pipe;
  logic [PW-1:0]          in_flat, out_flat;
`ifdef MEM_ARRAY_PIPE_PARITY_EN
  logic [WIDTH-1:0]       par;
`endif

  // Pack scalar, rows, then row-major 2-D elements into one flat word (parity on top)
  always_comb begin
    in_flat = '0;
    in_flat[WIDTH-1:0] = i3;
    for (int r = 0; r < ROWS; r++) begin
      in_flat[WIDTH*(1+r) +: WIDTH] = i34[r];
      for (int c = 0; c < COLS; c++)
        in_flat[WIDTH*(1+ROWS+r*COLS+c) +: WIDTH] = i345[r][c];
    end
`ifdef MEM_ARRAY_PIPE_PARITY_EN
    par = i3;
    for (int r = 0; r < ROWS; r++) begin
      par = par ^ i34[r];
      for (int c = 0; c < COLS; c++)
        par = par ^ i345[r][c];
    end
    in_flat[PW-1 -: WIDTH] = par;
`endif
  end

  assign vld_pipe[0]     = in_valid;
  assign dat_pipe[0]     = in_flat;
  assign in_ready        = rdy_pipe[0];
  assign rdy_pipe[DEPTH] = out_ready;
  assign out_valid       = vld_pipe[DEPTH];
  assign out_flat        = dat_pipe[DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    mem_array_skid #(.PW(PW)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld_pipe[g]),
      .in_ready  (rdy_pipe[g]),
      .in_data   (dat_pipe[g]),
      .out_valid (vld_pipe[g+1]),
      .out_ready (rdy_pipe[g+1]),
      .out_data  (dat_pipe[g+1])
    );
  end

  // Unpack the last stage back onto the array ports with the same index mapping
  always_comb begin
    o3 = out_flat[WIDTH-1:0];
    for (int r = 0; r < ROWS; r++) begin
      o34[r] = out_flat[WIDTH*(1+r) +: WIDTH];
      for (int c = 0; c < COLS; c++)
        o345[r][c] = out_flat[WIDTH*(1+ROWS+r*COLS+c) +: WIDTH];
    end
  end

`ifdef MEM_ARRAY_PIPE_PARITY_EN
  assign o_parity = out_flat[PW-1 -: WIDTH];
`endif

  // Count output handshakes; wraps naturally at the counter width
  always_ff @(posedge clk) begin
    if (rst)
      beat_cnt <= '0;
    else if (out_valid && out_ready)
      beat_cnt <= beat_cnt + 1'b1;
  end
endmodule

// File: tb/tb_mem_array_pipe.sv
// Directed bench for mem_array_pipe: reset, streaming latency/throughput,
// back-pressure capacity and hold, random handshakes, counter wrap, and
// reset with beats in flight. Outputs are sampled on the falling edge.
module tb_mem_array_pipe;
  import mem_array_pkg::*;
  localparam int WIDTH = WIDTH_DEF;
  localparam int ROWS  = ROWS_DEF;
  localparam int COLS  = COLS_DEF;
  localparam int DEPTH = DEPTH_DEF;
  localparam int FW    = WIDTH * (1 + ROWS + ROWS * COLS);

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] i3, o3;
  logic [WIDTH-1:0] i34 [ROWS];
  logic [WIDTH-1:0] o34 [ROWS];
  logic [WIDTH-1:0] i345 [ROWS][COLS];
  logic [WIDTH-1:0] o345 [ROWS][COLS];
  logic [15:0]      beat_cnt;
`ifdef MEM_ARRAY_PIPE_PARITY_EN
  logic [WIDTH-1:0] o_parity;
`endif

  mem_array_pipe #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .i3(i3), .i34(i34), .i345(i345),
    .out_valid(out_valid), .out_ready(out_ready),
    .o3(o3), .o34(o34), .o345(o345), .beat_cnt(beat_cnt)
`ifdef MEM_ARRAY_PIPE_PARITY_EN
    , .o_parity(o_parity)
`endif
  );

  always #5 clk = ~clk;

  int               vecs = 0, errs = 0;
  int               cyc = 0, outs = 0;
  int               first_in = -1, first_out = -1, last_out = -1;
  logic [FW-1:0]    exp_q [$];
  logic [WIDTH-1:0] par_q [$];
  logic             stalled = 1'b0;
  logic [FW-1:0]    held;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Canonical flattening: scalar, then 1-D elements, then 2-D row-major
  function automatic logic [FW-1:0] flat(input logic [WIDTH-1:0] s,
                                         input logic [WIDTH-1:0] a [ROWS],
                                         input logic [WIDTH-1:0] b [ROWS][COLS]);
    logic [FW-1:0] f;
    int k;
    f = '0;
    f[WIDTH-1:0] = s;
    k = 1;
    for (int r = 0; r < ROWS; r++) begin f[k*WIDTH +: WIDTH] = a[r]; k++; end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin f[k*WIDTH +: WIDTH] = b[r][c]; k++; end
    return f;
  endfunction

  function automatic logic [WIDTH-1:0] xor_all();
    logic [WIDTH-1:0] p;
    p = i3;
    for (int r = 0; r < ROWS; r++) begin
      p ^= i34[r];
      for (int c = 0; c < COLS; c++) p ^= i345[r][c];
    end
    return p;
  endfunction

  task automatic set_pat(input int n);
    i3 = WIDTH'(n);
    for (int r = 0; r < ROWS; r++) begin
      i34[r] = WIDTH'(16 * n + r);
      for (int c = 0; c < COLS; c++) i345[r][c] = WIDTH'(256 * r + c + n);
    end
  endtask

  task automatic set_rand();
    i3 = WIDTH'($urandom);
    for (int r = 0; r < ROWS; r++) begin
      i34[r] = WIDTH'($urandom);
      for (int c = 0; c < COLS; c++) i345[r][c] = WIDTH'($urandom);
    end
  endtask

  // One clock: score handshakes due at the coming edge, then advance to the next falling edge
  task automatic cycle();
    logic          ihs, ohs;
    logic [FW-1:0] e;
    logic [WIDTH-1:0] p;
    ihs = in_valid && in_ready && !rst;
    ohs = out_valid && out_ready && !rst;
    if (!rst && stalled) begin
      chk("hold_valid", FW'(out_valid), FW'(1'b1));
      chk("hold_data", flat(o3, o34, o345), held);
    end
    if (ohs) begin
      if (exp_q.size() == 0) begin
        chk("out_valid_without_beat", FW'(out_valid), FW'(1'b0));
      end else begin
        e = exp_q.pop_front();
        p = par_q.pop_front();
        chk("beat_data", flat(o3, o34, o345), e);
`ifdef MEM_ARRAY_PIPE_PARITY_EN
        chk("parity", FW'(o_parity), FW'(p));
`endif
        outs++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
    end
    if (ihs) begin
      exp_q.push_back(flat(i3, i34, i345));
      par_q.push_back(xor_all());
      if (first_in < 0) first_in = cyc;
    end
    stalled = !rst && out_valid && !out_ready;
    held    = flat(o3, o34, o345);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && exp_q.size() != 0; i++) cycle();
    chk("drain_left", FW'(exp_q.size()), FW'(0));
  endtask

  task automatic stream(input int base, input int count);
    int n = 0;
    for (int g = 0; g < count + 200 && n < count; g++) begin
      set_pat(base + n);
      in_valid = 1'b1;
      if (in_ready) begin cycle(); n++; end
      else cycle();
    end
    chk("stream_accepted", FW'(n), FW'(count));
    in_valid = 1'b0;
  endtask

  initial begin
    int acc;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    set_pat(5);
    @(negedge clk);

    // Reset held 3 cycles while a beat is offered: nothing may be captured
    repeat (3) cycle();
    chk("rst_out_valid", FW'(out_valid), FW'(0));
    chk("rst_o3", FW'(o3), FW'(0));
    chk("rst_beat_cnt", FW'(beat_cnt), FW'(0));
    rst = 1'b0; in_valid = 1'b0;
    cycle();
    chk("rst_in_ready", FW'(in_ready), FW'(1));
    chk("rst_no_capture", FW'(out_valid), FW'(0));

    // Streaming 100 beats with the consumer always ready
    first_in = -1; first_out = -1; last_out = -1;
    out_ready = 1'b1;
    stream(0, 100);
    drain(50);
    chk("latency", FW'(first_out - first_in), FW'(DEPTH));
    chk("throughput", FW'(last_out - first_out), FW'(99));
    chk("beat_cnt_100", FW'(beat_cnt), FW'(100));

    // Back-pressure: capacity is two beats per stage, head beat holds
    out_ready = 1'b0;
    acc = 0;
    for (int g = 0; g < 20; g++) begin
      set_pat(200 + acc);
      in_valid = 1'b1;
      if (!in_ready) break;
      cycle();
      acc++;
    end
    chk("capacity", FW'(acc), FW'(2 * DEPTH));
    repeat (3) cycle();
    chk("bp_in_ready", FW'(in_ready), FW'(0));
    chk("bp_head_o3", FW'(o3), FW'(200));
    chk("bp_out_valid", FW'(out_valid), FW'(1));
    drain(50);
    chk("beat_cnt_bp", FW'(beat_cnt), FW'(100 + 2 * DEPTH));

    // Random valid/ready with random payloads
    acc = 0;
    for (int g = 0; g < 5000 && acc < 400; g++) begin
      set_rand();
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) acc++;
      cycle();
    end
    chk("rand_accepted", FW'(acc), FW'(400));
    drain(100);
    chk("beat_cnt_rand", FW'(beat_cnt), FW'(16'(outs)));

    // Counter wrap: bring the total to 65535 handshakes, then one more
    out_ready = 1'b1;
    stream(1000, 65535 - outs);
    drain(50);
    chk("beat_cnt_ffff", FW'(beat_cnt), FW'(16'hFFFF));
    stream(3000, 1);
    drain(50);
    chk("beat_cnt_wrap", FW'(beat_cnt), FW'(0));

    // Reset with three beats in flight
    stream(4000, 2);
    drain(50);
    chk("beat_cnt_pre_rst", FW'(beat_cnt), FW'(2));
    out_ready = 1'b0;
    stream(5000, 3);
    chk("inflight_valid", FW'(out_valid), FW'(1));
    rst = 1'b1; in_valid = 1'b1; set_pat(6000);
    cycle();
    exp_q.delete(); par_q.delete();
    chk("midrst_out_valid", FW'(out_valid), FW'(0));
    chk("midrst_beat_cnt", FW'(beat_cnt), FW'(0));
    chk("midrst_o3", FW'(o3), FW'(0));
    rst = 1'b0; in_valid = 1'b0;
    cycle();
    chk("midrst_in_ready", FW'(in_ready), FW'(1));
    out_ready = 1'b1;
    stream(777, 1);
    drain(20);
    repeat (4) cycle();
    chk("post_rst_beat_cnt", FW'(beat_cnt), FW'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
